// File: rtl/freq_meter.sv
// freq_meter: gated-window frequency meter counting sig_in rising edges per GATE_CYCLES clk window.
// Define FREQ_METER_RANGE_EN to add the in_range output (MIN_EDGES..MAX_EDGES, inclusive).
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MIN_EDGES   = 0,
    parameter int unsigned MAX_EDGES   = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             ovf,
`ifdef FREQ_METER_RANGE_EN
    output logic             in_range,
`endif
    output logic             busy
);

    localparam int unsigned       GW           = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]     LP_GATE_LOAD = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LP_CNT_MAX   = '1;

    if (GATE_CYCLES < 2 || GATE_CYCLES > (1 << 24) || MIN_EDGES > MAX_EDGES) begin : g_bad_params
        $error("freq_meter: illegal GATE_CYCLES or MIN_EDGES > MAX_EDGES");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_GATE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1, r_s2, r_s3;
    logic [GW-1:0]    r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_ovf_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic             r_ovf;
    logic             w_edge;
    logic             w_at_max;
    logic [CNT_W-1:0] w_final_cnt;
    logic             w_final_ovf;

    // Two-flop synchronizer plus a delay flop for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge      = r_s2 & ~r_s3;
    assign w_at_max    = (r_edge_cnt == LP_CNT_MAX);
    assign w_final_cnt = (w_edge && !w_at_max) ? r_edge_cnt + 1'b1 : r_edge_cnt;
    assign w_final_ovf = r_ovf_acc | (w_edge & w_at_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (en) w_state_nxt = S_ARM;
            S_ARM:   w_state_nxt = S_GATE;
            S_GATE:  if (!en) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef FREQ_METER_RANGE_EN
    localparam int unsigned CW = (CNT_W > 32) ? CNT_W : 32;
    logic r_in_range;
    logic w_in_range_nxt;

    assign w_in_range_nxt = (CW'(w_final_cnt) >= CW'(MIN_EDGES)) &&
                            (CW'(w_final_cnt) <= CW'(MAX_EDGES)) && !w_final_ovf;
    assign in_range = r_in_range;
`endif

    // An en drop in GATE aborts the window: results hold, no valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_acc  <= 1'b0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
`ifdef FREQ_METER_RANGE_EN
            r_in_range <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_ARM: begin
                    r_edge_cnt <= '0;
                    r_ovf_acc  <= 1'b0;
                    r_gate_cnt <= LP_GATE_LOAD;
                end
                S_GATE: begin
                    if (en) begin
                        if (r_gate_cnt != '0) begin
                            r_gate_cnt <= r_gate_cnt - 1'b1;
                            if (w_edge) begin
                                if (w_at_max) r_ovf_acc <= 1'b1;
                                else          r_edge_cnt <= r_edge_cnt + 1'b1;
                            end
                        end else begin
                            r_count    <= w_final_cnt;
                            r_ovf      <= w_final_ovf;
                            r_valid    <= 1'b1;
`ifdef FREQ_METER_RANGE_EN
                            r_in_range <= w_in_range_nxt;
`endif
                            r_edge_cnt <= '0;
                            r_ovf_acc  <= 1'b0;
                            r_gate_cnt <= LP_GATE_LOAD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign count = r_count;
    assign valid = r_valid;
    assign ovf   = r_ovf;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: a 16-bit and a 4-bit counter instance share all inputs;
// expected per-window edge counts are queued when a pattern is driven and popped on valid.
module tb_freq_meter;

    localparam int unsigned GC = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sig_in;
    logic [15:0] count16;
    logic        valid16, ovf16, busy16;
    logic [3:0]  count4;
    logic        valid4, ovf4, busy4;
`ifdef FREQ_METER_RANGE_EN
    logic        inr16, inr4;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          skip;
        int unsigned edges;
    } exp_t;

    exp_t sb[$];
    int   cyc        = 0;
    int   last_valid = -1;
    int   t_en       = -1;
    int   nvalid     = 0;
    int   sig_mode   = 10;

    always #5 clk = ~clk;

    freq_meter #(
        .GATE_CYCLES (GC),
        .CNT_W       (16),
        .MIN_EDGES   (9),
        .MAX_EDGES   (11)
    ) dut16 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sig_in   (sig_in),
        .count    (count16),
        .valid    (valid16),
        .ovf      (ovf16),
`ifdef FREQ_METER_RANGE_EN
        .in_range (inr16),
`endif
        .busy     (busy16)
    );

    freq_meter #(
        .GATE_CYCLES (GC),
        .CNT_W       (4),
        .MIN_EDGES   (9),
        .MAX_EDGES   (11)
    ) dut4 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sig_in   (sig_in),
        .count    (count4),
        .valid    (valid4),
        .ovf      (ovf4),
`ifdef FREQ_METER_RANGE_EN
        .in_range (inr4),
`endif
        .busy     (busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input bit skip, input int unsigned edges, input int unsigned n);
        exp_t ent;
        ent.skip  = skip;
        ent.edges = edges;
        for (int i = 0; i < int'(n); i++) sb.push_back(ent);
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sb.size()), 0);
    endtask

    // sig_mode: 0 hold low, 1 hold high, otherwise square-wave period in clk cycles
    initial begin
        int ph = 0;
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            if (sig_mode == 0)      sig_in = 1'b0;
            else if (sig_mode == 1) sig_in = 1'b1;
            else begin
                sig_in = (ph < sig_mode / 2);
                ph = (ph + 1) % sig_mode;
            end
        end
    end

    initial begin
        exp_t        ent;
        int unsigned c4;
        int          o4;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (valid16 || valid4) begin
                nvalid++;
                check("valid_pair", 32'(valid4), 32'(valid16));
                if (last_valid >= 0)  check("valid_period", 32'(cyc - last_valid), GC);
                else if (t_en >= 0)   check("first_valid_latency", 32'(cyc - t_en), GC + 1);
                last_valid = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(valid16), 0);
                end else begin
                    ent = sb.pop_front();
                    if (!ent.skip) begin
                        c4 = (ent.edges > 15) ? 15 : ent.edges;
                        o4 = (ent.edges > 15) ? 1 : 0;
                        check("count16", 32'(count16), ent.edges);
                        check("ovf16", 32'(ovf16), 0);
                        check("count4", 32'(count4), c4);
                        check("ovf4", 32'(ovf4), 32'(o4));
`ifdef FREQ_METER_RANGE_EN
                        check("in_range16", 32'(inr16),
                              (ent.edges >= 9 && ent.edges <= 11) ? 1 : 0);
                        check("in_range4", 32'(inr4),
                              (c4 >= 9 && c4 <= 11 && o4 == 0) ? 1 : 0);
`endif
                    end
                end
            end
        end
    end

    initial begin
        int n0;
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_count16", 32'(count16), 0);
        check("rst_count4", 32'(count4), 0);
        check("rst_valid", 32'(valid16 | valid4), 0);
        check("rst_ovf", 32'(ovf16 | ovf4), 0);
        check("rst_busy", 32'(busy16 | busy4), 0);

        // Let the synchronizer settle before the first window
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(busy16), 0);
        en = 1'b1;
        t_en = cyc + 1;
        last_valid = -1;
        @(negedge clk);
        check("arm_busy", 32'(busy16), 1);
        push(1'b0, 10, 3);
        wait_empty("periodic_done");

        repeat (50) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("abort_busy16", 32'(busy16), 0);
        check("abort_busy4", 32'(busy4), 0);
        check("abort_count16", 32'(count16), 10);
        check("abort_count4", 32'(count4), 10);
        n0 = nvalid;
        repeat (150) @(negedge clk);
        check("abort_no_valid", 32'(nvalid), 32'(n0));
        check("abort_hold_count", 32'(count16), 10);

        en = 1'b1;
        t_en = cyc + 1;
        last_valid = -1;
        push(1'b0, 10, 2);
        wait_empty("restart_done");

        sig_mode = 0;
        push(1'b1, 0, 1);
        push(1'b0, 0, 2);
        wait_empty("static_low_done");

        sig_mode = 1;
        push(1'b1, 0, 1);
        push(1'b0, 0, 2);
        wait_empty("static_high_done");

        sig_mode = 4;
        push(1'b1, 0, 1);
        push(1'b0, 25, 2);
        wait_empty("period4_done");

        sig_mode = 10;
        push(1'b1, 0, 1);
        push(1'b0, 10, 2);
        wait_empty("period10_done");

        sig_mode = 5;
        push(1'b1, 0, 1);
        push(1'b0, 20, 1);
        wait_empty("period5_done");

        repeat (40) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_count16", 32'(count16), 0);
        check("midrst_count4", 32'(count4), 0);
        check("midrst_ovf", 32'(ovf16 | ovf4), 0);
        check("midrst_valid", 32'(valid16 | valid4), 0);
        check("midrst_busy", 32'(busy16 | busy4), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        t_en = cyc + 1;
        last_valid = -1;
        push(1'b1, 0, 1);
        push(1'b0, 20, 1);
        wait_empty("post_rst_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
